// File: rtl/sum_hls_axis_stall_detector.sv
// Per-channel AXI-Stream stall detector: flags a channel after THRESH consecutive stalled cycles
// and keeps a sticky record of the first channel that blocked.
module sum_hls_axis_stall_detector #(
  parameter int unsigned       NUM_CH   = 2,
  parameter int unsigned       THRESH   = 16,
  parameter int unsigned       CNT_W    = $clog2(THRESH + 1),
  parameter logic [NUM_CH-1:0] DIR_MASK = 2'b10,
  parameter int unsigned       IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] ch_tvalid,
  input  logic [NUM_CH-1:0] ch_tready,
  input  logic              inst_idle,
  input  logic              clear,
  output logic [NUM_CH-1:0] axis_block_sigs,
  output logic              stall_event,
  output logic              first_valid,
  output logic [IDX_W-1:0]  first_ch
);

  typedef enum logic [1:0] {StIdle, StCount, StBlocked} st_e;

  st_e              st_q  [NUM_CH];
  st_e              st_d  [NUM_CH];
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic [CNT_W-1:0] cnt_d [NUM_CH];

  logic [NUM_CH-1:0] stall;
  logic [NUM_CH-1:0] enter;
  logic [IDX_W-1:0]  first_idx;
  logic              stall_event_q, stall_event_d;
  logic              first_valid_q, first_valid_d;
  logic [IDX_W-1:0]  first_ch_q, first_ch_d;

  // Outputs stall when the kernel cannot write; inputs stall when it waits for data.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (DIR_MASK[i]) begin
        stall[i] = ch_tvalid[i] & ~ch_tready[i] & ~inst_idle;
      end else begin
        stall[i] = ch_tready[i] & ~ch_tvalid[i] & ~inst_idle;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      enter[i] = 1'b0;
      unique case (st_q[i])
        StIdle: begin
          if (stall[i]) begin
            cnt_d[i] = CNT_W'(1);
            if (THRESH == 1) begin
              st_d[i]  = StBlocked;
              enter[i] = 1'b1;
            end else begin
              st_d[i] = StCount;
            end
          end else begin
            cnt_d[i] = '0;
          end
        end
        StCount: begin
          if (stall[i]) begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
            if (cnt_q[i] == CNT_W'(THRESH - 1)) begin
              st_d[i]  = StBlocked;
              enter[i] = 1'b1;
            end
          end else begin
            st_d[i]  = StIdle;
            cnt_d[i] = '0;
          end
        end
        StBlocked: begin
          if (stall[i]) begin
            cnt_d[i] = CNT_W'(THRESH);
          end else begin
            st_d[i]  = StIdle;
            cnt_d[i] = '0;
          end
        end
        default: begin
          st_d[i]  = StIdle;
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Scan downward so the lowest entering index wins.
  always_comb begin
    first_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (enter[i]) begin
        first_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    stall_event_d = |enter;
    first_valid_d = first_valid_q;
    first_ch_d    = first_ch_q;
    if (clear) begin
      first_valid_d = 1'b0;
      first_ch_d    = '0;
    end else if (!first_valid_q && |enter) begin
      first_valid_d = 1'b1;
      first_ch_d    = first_idx;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= StIdle;
        cnt_q[i] <= '0;
      end
      stall_event_q <= 1'b0;
      first_valid_q <= 1'b0;
      first_ch_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      stall_event_q <= stall_event_d;
      first_valid_q <= first_valid_d;
      first_ch_q    <= first_ch_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      axis_block_sigs[i] = (st_q[i] == StBlocked);
    end
  end

  assign stall_event = stall_event_q;
  assign first_valid = first_valid_q;
  assign first_ch    = first_ch_q;

endmodule

// File: tb/tb_sum_hls_axis_stall_detector.sv
// Bench for the stall detector: two instances (THRESH=4 and THRESH=1) checked every cycle against
// a run-length model, plus directed literal checks.
module tb_sum_hls_axis_stall_detector;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] ch_tvalid = 2'b00;
  logic [1:0] ch_tready = 2'b00;
  logic       inst_idle = 1'b0;
  logic       clear = 1'b0;

  logic [1:0] blk_a, blk_b;
  logic       ev_a, ev_b, fv_a, fv_b;
  logic [0:0] fc_a, fc_b;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clock = ~clock;

  sum_hls_axis_stall_detector #(.NUM_CH(2), .THRESH(4)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .ch_tvalid(ch_tvalid), .ch_tready(ch_tready),
    .inst_idle(inst_idle), .clear(clear), .axis_block_sigs(blk_a), .stall_event(ev_a),
    .first_valid(fv_a), .first_ch(fc_a)
  );

  sum_hls_axis_stall_detector #(.NUM_CH(2), .THRESH(1)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .ch_tvalid(ch_tvalid), .ch_tready(ch_tready),
    .inst_idle(inst_idle), .clear(clear), .axis_block_sigs(blk_b), .stall_event(ev_b),
    .first_valid(fv_b), .first_ch(fc_b)
  );

  // Model: consecutive-stall run length per channel; flagged once the run reaches the threshold.
  int thr [2] = '{4, 1};
  int run [2][2];
  bit m_ev [2];
  bit m_fv [2];
  int m_fc [2];

  function automatic bit is_stall(int c);
    if (inst_idle) return 1'b0;
    if (c == 1) return ch_tvalid[1] && !ch_tready[1];
    return ch_tready[0] && !ch_tvalid[0];
  endfunction

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        run[k][0] = 0; run[k][1] = 0;
        m_ev[k] = 1'b0; m_fv[k] = 1'b0; m_fc[k] = 0;
      end else begin
        int low;
        low = -1;
        for (int c = 0; c < 2; c++) begin
          if (is_stall(c)) begin
            if (run[k][c] < 100000) run[k][c]++;
          end else begin
            run[k][c] = 0;
          end
          if (run[k][c] == thr[k] && low < 0) low = c;
        end
        m_ev[k] = (low >= 0);
        if (clear) begin
          m_fv[k] = 1'b0; m_fc[k] = 0;
        end else if (!m_fv[k] && low >= 0) begin
          m_fv[k] = 1'b1; m_fc[k] = low;
        end
      end
    end
  end

  function automatic logic [1:0] m_blk(int k);
    logic [1:0] r;
    for (int c = 0; c < 2; c++) r[c] = (run[k][c] >= thr[k]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("a.blk", 32'(blk_a), 32'(m_blk(0)));
      chk("a.ev", 32'(ev_a), 32'(m_ev[0]));
      chk("a.fv", 32'(fv_a), 32'(m_fv[0]));
      chk("a.fc", 32'(fc_a), 32'(m_fc[0]));
      chk("b.blk", 32'(blk_b), 32'(m_blk(1)));
      chk("b.ev", 32'(ev_b), 32'(m_ev[1]));
      chk("b.fv", 32'(fv_b), 32'(m_fv[1]));
      chk("b.fc", 32'(fc_b), 32'(m_fc[1]));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  int evs;

  initial begin
    // Reset with both channels stalling (ch0 input: tready & ~tvalid, ch1 output: tvalid & ~tready).
    ch_tvalid = 2'b10; ch_tready = 2'b01;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    chk("rst.blk", 32'(blk_a), 32'h0);
    chk("rst.ev", 32'(ev_a), 32'h0);
    chk("rst.fv", 32'(fv_a), 32'h0);
    reset_n = 1'b1;
    tick(3);
    chk("pre4.blk", 32'(blk_a), 32'h0);
    tick(1);
    chk("sim.blk", 32'(blk_a), 32'h3);
    chk("sim.ev", 32'(ev_a), 32'h1);
    chk("sim.fc", 32'(fc_a), 32'h0);
    chk("sim.fv", 32'(fv_a), 32'h1);
    tick(1);
    chk("sim.ev1", 32'(ev_a), 32'h0);
    ch_tvalid = 2'b00; ch_tready = 2'b00;
    tick(1);
    chk("sim.drop", 32'(blk_a), 32'h0);
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("clr.fv", 32'(fv_a), 32'h0);

    // Output-channel block on ch1.
    ch_tvalid = 2'b10;
    tick(3);
    chk("out.pre", 32'(blk_a), 32'h0);
    tick(1);
    chk("out.blk", 32'(blk_a), 32'h2);
    chk("out.ev", 32'(ev_a), 32'h1);
    chk("out.fc", 32'(fc_a), 32'h1);
    tick(2);
    chk("out.hold", 32'(blk_a), 32'h2);
    ch_tvalid = 2'b00;
    tick(1);
    chk("out.clr", 32'(blk_a), 32'h0);

    // Handshake breaks a run on ch0.
    ch_tready = 2'b01;
    for (int i = 0; i < 7; i++) begin
      ch_tvalid = (i == 3) ? 2'b01 : 2'b00;
      tick(1);
      chk("hs.blk0", 32'(blk_a[0]), 32'h0);
      chk("hs.ev", 32'(ev_a), 32'h0);
    end
    ch_tready = 2'b00; ch_tvalid = 2'b00;
    tick(1);

    // Idle masking keeps the record; clear then drops it.
    clear = 1'b1; tick(1); clear = 1'b0;
    ch_tvalid = 2'b10;
    tick(4);
    chk("idl.blk", 32'(blk_a), 32'h2);
    chk("idl.fc", 32'(fc_a), 32'h1);
    inst_idle = 1'b1;
    tick(1);
    chk("idl.clr", 32'(blk_a), 32'h0);
    chk("idl.fv", 32'(fv_a), 32'h1);
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("idl.fv0", 32'(fv_a), 32'h0);
    chk("idl.fc0", 32'(fc_a), 32'h0);

    // Clear coinciding with an entry wins.
    inst_idle = 1'b0;
    tick(3);
    clear = 1'b1; tick(1); clear = 1'b0;
    chk("cw.blk", 32'(blk_a), 32'h2);
    chk("cw.ev", 32'(ev_a), 32'h1);
    chk("cw.fv", 32'(fv_a), 32'h0);
    ch_tvalid = 2'b00;
    tick(1);

    // Reset mid-count discards history.
    ch_tready = 2'b01;
    tick(2);
    reset_n = 1'b0; tick(1); reset_n = 1'b1;
    tick(3);
    chk("mid.blk", 32'(blk_a), 32'h0);
    ch_tready = 2'b00;
    tick(1);

    // Saturation on ch0; THRESH=1 instance flags after one edge.
    ch_tready = 2'b01;
    tick(1);
    chk("t1.blk", 32'(blk_b), 32'h1);
    chk("t1.ev", 32'(ev_b), 32'h1);
    evs = 0;
    for (int i = 2; i <= 1000; i++) begin
      tick(1);
      if (ev_a) evs++;
      if (i >= 4) chk("sat.blk", 32'(blk_a[0]), 32'h1);
    end
    chk("sat.evs", 32'(evs), 32'h1);
    ch_tready = 2'b00;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
